// File: rtl/nonce_collect_hub.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_collect_hub
//  Description : Collects golden-nonce pulses from SLAVES channels into
//                per-channel hold registers. A round-robin arbiter moves them
//                into a shared FIFO tagged with the channel ID, and an output
//                FSM hands them to serial_transmit through a send/busy
//                handshake. Nonces overwritten before they could be queued
//                are counted in a saturating drop counter.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           uart_clk domain clock
//    reset         synchronous, active-high
//    new_nonces    per-channel one-cycle valid pulse
//    slave_nonces  channel i at [i*NONCE_WIDTH +: NONCE_WIDTH]
//    flush         discard every buffered nonce (new work arrived)
//    serial_busy   busy flag from serial_transmit
//    serial_send   one-cycle start pulse to serial_transmit
//    golden_nonce  nonce being transmitted, stable until the next send
//    golden_chan   channel ID of golden_nonce
//    fifo_count    current FIFO occupancy
//    drop_count    saturating count of lost nonces
//  Build option
//    NONCE_DEDUP_EN : when defined, a granted nonce equal to the last pushed
//                     nonce is discarded instead of being queued.
// ============================================================================
module nonce_collect_hub #(
    parameter  int SLAVES      = 2,
    parameter  int NONCE_WIDTH = 32,
    parameter  int FIFO_DEPTH  = 8,
    parameter  int CNT_WIDTH   = 8,
    localparam int CW          = (SLAVES > 1) ? $clog2(SLAVES) : 1,
    localparam int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SLAVES-1:0]             new_nonces,
    input  logic [SLAVES*NONCE_WIDTH-1:0] slave_nonces,
    input  logic                          flush,
    input  logic                          serial_busy,
    output logic                          serial_send,
    output logic [NONCE_WIDTH-1:0]        golden_nonce,
    output logic [CW-1:0]                 golden_chan,
    output logic [AW:0]                   fifo_count,
    output logic [CNT_WIDTH-1:0]          drop_count
);

    localparam int EW = CW + NONCE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    logic [NONCE_WIDTH-1:0] hold_q [SLAVES];
    logic [SLAVES-1:0]      hold_valid_q, hold_valid_d;
    logic [EW-1:0]          fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]   drop_count_q, drop_count_d;
    state_t                 state_q;
    logic [1:0]             tmo_q;
    logic                   serial_send_q;
    logic [NONCE_WIDTH-1:0] golden_nonce_q;
    logic [CW-1:0]          golden_chan_q;

    logic                   empty_c, full_c, pop_c;
    logic                   found_c, grant_c, push_c, dup_c;
    logic [CW-1:0]          grant_chan_c;
    logic [CW:0]            idx_c;
    logic [NONCE_WIDTH-1:0] grant_nonce_c;
    logic [4:0]             drop_num_c;
    logic [CNT_WIDTH+4:0]   drop_sum_c;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign empty_c    = (fifo_count == '0);
    assign full_c     = (fifo_count == (AW+1)'(FIFO_DEPTH));
    // Popping is suppressed during flush so a discarded entry is never sent.
    assign pop_c      = (state_q == ST_IDLE) && !empty_c && !serial_busy && !flush;

    // Round-robin search: first valid hold starting at rr_ptr, wrapping.
    always_comb begin
        found_c      = 1'b0;
        grant_chan_c = '0;
        idx_c        = '0;
        for (int k = 0; k < SLAVES; k++) begin
            idx_c = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (idx_c >= (CW+1)'(SLAVES)) begin
                idx_c = idx_c - (CW+1)'(SLAVES);
            end
            if (!found_c && hold_valid_q[idx_c[CW-1:0]]) begin
                found_c      = 1'b1;
                grant_chan_c = idx_c[CW-1:0];
            end
        end
    end

    assign grant_nonce_c = hold_q[grant_chan_c];
    // A full FIFO still accepts a push in the cycle it pops.
    assign grant_c       = found_c && (!full_c || pop_c) && !flush;
    assign push_c        = grant_c && !dup_c;

`ifdef NONCE_DEDUP_EN
    logic                   last_valid_q;
    logic [NONCE_WIDTH-1:0] last_nonce_q;

    assign dup_c = last_valid_q && (grant_nonce_c == last_nonce_q);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            last_valid_q <= 1'b0;
            last_nonce_q <= '0;
        end else if (push_c) begin
            last_valid_q <= 1'b1;
            last_nonce_q <= grant_nonce_c;
        end
    end
`else
    assign dup_c = 1'b0;
`endif

    // Capture / release of the hold registers and drop accounting. A reload
    // in the cycle the channel is granted is not a loss: the old value
    // leaves through the arbiter.
    always_comb begin
        hold_valid_d = hold_valid_q;
        drop_num_c   = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (flush) begin
                hold_valid_d[i] = 1'b0;
            end else if (new_nonces[i]) begin
                hold_valid_d[i] = 1'b1;
                if (hold_valid_q[i] && !(grant_c && (grant_chan_c == CW'(i)))) begin
                    drop_num_c = drop_num_c + 5'd1;
                end
            end else if (grant_c && (grant_chan_c == CW'(i))) begin
                hold_valid_d[i] = 1'b0;
            end
        end
    end

    assign drop_sum_c   = {5'd0, drop_count_q} + {{CNT_WIDTH{1'b0}}, drop_num_c};
    assign drop_count_d = (drop_sum_c > {5'd0, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}}
                                                                   : drop_sum_c[CNT_WIDTH-1:0];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_c) begin
            rr_ptr_d = (grant_chan_c == CW'(SLAVES-1)) ? '0 : grant_chan_c + CW'(1);
        end
    end

    // Hold data needs no reset; hold_valid qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i]) begin
                hold_q[i] <= slave_nonces[i*NONCE_WIDTH +: NONCE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {grant_chan_c, grant_nonce_c};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rr_ptr_q     <= '0;
            drop_count_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_count_q <= drop_count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_c)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Output handshake FSM. WAIT_ACK gives up after four busy-free cycles so
    // a missed acknowledge cannot stall the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tmo_q          <= '0;
            serial_send_q  <= 1'b0;
            golden_nonce_q <= '0;
            golden_chan_q  <= '0;
        end else begin
            serial_send_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_c) begin
                        {golden_chan_q, golden_nonce_q} <= fifo_mem_q[rd_ptr_q[AW-1:0]];
                        serial_send_q <= 1'b1;
                        tmo_q         <= '0;
                        state_q       <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (serial_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (tmo_q == 2'd3) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 2'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!serial_busy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign serial_send  = serial_send_q;
    assign golden_nonce = golden_nonce_q;
    assign golden_chan  = golden_chan_q;
    assign drop_count   = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_collect_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nonce_collect_hub
//  Description : Directed self-checking bench. Instance A (4 channels,
//                4-deep FIFO) covers burst, single find, collision, flush and
//                dedup; instance B (2 channels, 2-deep FIFO) covers overflow.
//                Each instance has a small serial_transmit model that raises
//                busy for three cycles after every send.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nonce_collect_hub;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- instance A ----------------
    logic [3:0]   a_new = '0;
    logic [127:0] a_data = '0;
    logic         a_flush = 1'b0;
    logic         a_force = 1'b0;
    wire          a_busy;
    wire          a_send;
    wire [31:0]   a_gn;
    wire [1:0]    a_gc;
    wire [2:0]    a_fc;
    wire [7:0]    a_dc;
    logic [1:0]   a_bcnt;
    logic [39:0]  a_log [$];

    nonce_collect_hub #(.SLAVES(4), .NONCE_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(8)) u_dut_a (
        .clk(clk), .reset(reset), .new_nonces(a_new), .slave_nonces(a_data),
        .flush(a_flush), .serial_busy(a_busy), .serial_send(a_send),
        .golden_nonce(a_gn), .golden_chan(a_gc), .fifo_count(a_fc), .drop_count(a_dc)
    );

    always @(posedge clk) begin
        if (reset)              a_bcnt <= 2'd0;
        else if (a_send)        a_bcnt <= 2'd3;
        else if (a_bcnt != 2'd0) a_bcnt <= a_bcnt - 2'd1;
    end
    assign a_busy = a_force | (a_bcnt != 2'd0);

    always @(negedge clk) if (a_send) a_log.push_back({8'(a_gc), a_gn});

    // ---------------- instance B ----------------
    logic [1:0]   b_new = '0;
    logic [63:0]  b_data = '0;
    logic         b_flush = 1'b0;
    logic         b_force = 1'b0;
    wire          b_busy;
    wire          b_send;
    wire [31:0]   b_gn;
    wire [0:0]    b_gc;
    wire [1:0]    b_fc;
    wire [7:0]    b_dc;
    logic [1:0]   b_bcnt;
    logic [39:0]  b_log [$];

    nonce_collect_hub #(.SLAVES(2), .NONCE_WIDTH(32), .FIFO_DEPTH(2), .CNT_WIDTH(8)) u_dut_b (
        .clk(clk), .reset(reset), .new_nonces(b_new), .slave_nonces(b_data),
        .flush(b_flush), .serial_busy(b_busy), .serial_send(b_send),
        .golden_nonce(b_gn), .golden_chan(b_gc), .fifo_count(b_fc), .drop_count(b_dc)
    );

    always @(posedge clk) begin
        if (reset)              b_bcnt <= 2'd0;
        else if (b_send)        b_bcnt <= 2'd3;
        else if (b_bcnt != 2'd0) b_bcnt <= b_bcnt - 2'd1;
    end
    assign b_busy = b_force | (b_bcnt != 2'd0);

    always @(negedge clk) if (b_send) b_log.push_back({8'(b_gc), b_gn});

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            tests_run++;
            if ({a_send, a_gn, a_gc, a_fc, a_dc} !== 46'd0) begin
                tests_failed++;
                $display("FAIL reset_a[%0d]: send=%b gn=%h gc=%0d fc=%0d dc=%0d, required all 0",
                         r, a_send, a_gn, a_gc, a_fc, a_dc);
            end
            tests_run++;
            if ({b_send, b_gn, b_gc, b_fc, b_dc} !== 44'd0) begin
                tests_failed++;
                $display("FAIL reset_b[%0d]: send=%b gn=%h gc=%0d fc=%0d dc=%0d, required all 0",
                         r, b_send, b_gn, b_gc, b_fc, b_dc);
            end
            reset = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_burst();
        int peak = 0;
        logic [39:0] exp;
        a_log.delete();
        a_new  = 4'hF;
        a_data = {32'h13, 32'h12, 32'h11, 32'h10};
        @(negedge clk);
        a_new = '0;
        for (int c = 0; c < 80 && a_log.size() < 4; c++) begin
            if (int'(a_fc) > peak) peak = int'(a_fc);
            @(negedge clk);
        end
        tests_run++;
        if (a_log.size() != 4) begin
            tests_failed++;
            $display("FAIL burst_count: got %0d sends, required 4", a_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp = {8'(k), 32'(32'h10 + k)};
                tests_run++;
                if (a_log[k] !== exp) begin
                    tests_failed++;
                    $display("FAIL burst_order[%0d]: got %h, required %h", k, a_log[k], exp);
                end
            end
        end
        tests_run++;
        if (peak != 3) begin
            tests_failed++;
            $display("FAIL burst_peak: got %0d, required 3", peak);
        end
        tests_run++;
        if (a_dc !== 8'd0) begin
            tests_failed++;
            $display("FAIL burst_drop: got %0d, required 0", a_dc);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_find();
        logic [3:0] seen;
        a_log.delete();
        a_new = 4'b0010;
        a_data[63:32] = 32'hDEADBEEF;
        @(negedge clk);                 // after edge N
        a_new = '0;
        seen[0] = a_send;
        @(negedge clk);                 // after edge N+1
        seen[1] = a_send;
        @(negedge clk);                 // after edge N+2
        seen[2] = a_send;
        tests_run++;
        if (a_gn !== 32'hDEADBEEF || a_gc !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_data: got nonce %h chan %0d, required deadbeef chan 1", a_gn, a_gc);
        end
        @(negedge clk);
        seen[3] = a_send;
        tests_run++;
        if (seen !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_latency: send pattern N..N+3 = %b, required 0100 (lsb first)", seen);
        end
        repeat (15) @(negedge clk);
        tests_run++;
        if (a_log.size() != 1) begin
            tests_failed++;
            $display("FAIL single_count: got %0d sends, required 1", a_log.size());
        end
    endtask

    task automatic test_collision();
        logic [7:0] d0 = a_dc;
        a_log.delete();
        a_new = 4'b0001;
        a_data[31:0] = 32'hC0DE0001;
        @(negedge clk);
        a_data[31:0] = 32'hC0DE0002;
        @(negedge clk);
        a_new = '0;
        for (int c = 0; c < 40 && a_log.size() < 2; c++) @(negedge clk);
        tests_run++;
        if (a_log.size() != 2) begin
            tests_failed++;
            $display("FAIL collision_count: got %0d sends, required 2", a_log.size());
        end else begin
            tests_run++;
            if (a_log[0] !== {8'd0, 32'hC0DE0001} || a_log[1] !== {8'd0, 32'hC0DE0002}) begin
                tests_failed++;
                $display("FAIL collision_data: got %h %h, required 00c0de0001 00c0de0002",
                         a_log[0], a_log[1]);
            end
        end
        tests_run++;
        if (a_dc !== d0) begin
            tests_failed++;
            $display("FAIL collision_drop: got %0d, required %0d", a_dc, d0);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_flush();
        logic [7:0] d0 = a_dc;
        a_log.delete();
        a_force = 1'b1;
        a_new   = 4'b0111;
        a_data  = {32'h0, 32'hF2, 32'hF1, 32'hF0};
        @(negedge clk);
        a_new = '0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (a_fc !== 3'd3) begin
            tests_failed++;
            $display("FAIL flush_fill: got fifo_count %0d, required 3", a_fc);
        end
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
        tests_run++;
        if (a_fc !== 3'd0) begin
            tests_failed++;
            $display("FAIL flush_empty: got fifo_count %0d, required 0", a_fc);
        end
        a_force = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (a_log.size() != 0 || a_dc !== d0) begin
            tests_failed++;
            $display("FAIL flush_after: got %0d sends drop %0d, required 0 sends drop %0d",
                     a_log.size(), a_dc, d0);
        end
    endtask

    task automatic test_dedup();
        int exp_n;
        logic [31:0] vals [3];
`ifdef NONCE_DEDUP_EN
        exp_n = 2;
`else
        exp_n = 3;
`endif
        vals[0] = 32'hABCD0001;
        vals[1] = 32'hABCD0001;
        vals[2] = 32'hABCD0002;
        a_log.delete();
        for (int k = 0; k < 3; k++) begin
            a_new = 4'b0001;
            a_data[31:0] = vals[k];
            @(negedge clk);
            a_new = '0;
            repeat (3) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        tests_run++;
        if (a_log.size() != exp_n) begin
            tests_failed++;
            $display("FAIL dedup_count: got %0d sends, required %0d", a_log.size(), exp_n);
        end else begin
            tests_run++;
            if (a_log[exp_n-1] !== {8'd0, 32'hABCD0002}) begin
                tests_failed++;
                $display("FAIL dedup_last: got %h, required 00abcd0002", a_log[exp_n-1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [39:0] exp [3];
        exp[0] = {8'd0, 32'h101};
        exp[1] = {8'd0, 32'h102};
        exp[2] = {8'd0, 32'h105};
        b_log.delete();
        b_force = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            b_new = 2'b01;
            b_data[31:0] = 32'(32'h100 + k);
            @(negedge clk);
        end
        b_new = '0;
        @(negedge clk);
        tests_run++;
        if (b_fc !== 2'd2) begin
            tests_failed++;
            $display("FAIL overflow_fill: got fifo_count %0d, required 2", b_fc);
        end
        tests_run++;
        if (b_dc !== 8'd2) begin
            tests_failed++;
            $display("FAIL overflow_drop: got %0d, required 2", b_dc);
        end
        tests_run++;
        if (b_log.size() != 0) begin
            tests_failed++;
            $display("FAIL overflow_busy: got %0d sends while busy, required 0", b_log.size());
        end
        b_force = 1'b0;
        for (int c = 0; c < 60 && b_log.size() < 3; c++) @(negedge clk);
        tests_run++;
        if (b_log.size() != 3) begin
            tests_failed++;
            $display("FAIL overflow_count: got %0d sends, required 3", b_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (b_log[k] !== exp[k]) begin
                    tests_failed++;
                    $display("FAIL overflow_order[%0d]: got %h, required %h", k, b_log[k], exp[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_single_find();
        test_collision();
        test_flush();
        test_dedup();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
